// File: rtl/dmem_responder.sv
// Data-memory responder: single-outstanding request/grant port in front of a
// 64-bit word array, answering each access with a one-cycle rvalid pulse after LATENCY wait cycles.
module dmem_responder #(
    parameter int DEPTH_WORDS = 4096,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [7:0]  be_i,
    input  logic [63:0] addr_i,
    input  logic [63:0] wdata_i,
    output logic        gnt_o,
    output logic        rvalid_o,
    output logic [63:0] rdata_o,
    output logic        err_o
);

    localparam int AW = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [3:0]  r_cnt;
    logic [3:0]  w_cnt_nxt;

    logic        r_we;
    logic [7:0]  r_be;
    logic [63:0] r_addr;
    logic [63:0] r_wdata;
    logic [63:0] r_rdata;
    logic        r_err;

    logic [63:0] r_mem [DEPTH_WORDS];

    logic        w_hs;
    logic        w_commit;
    logic        w_acc_we;
    logic [7:0]  w_acc_be;
    logic [63:0] w_acc_addr;
    logic [63:0] w_acc_wdata;
    logic [63:0] w_word_addr;
    logic        w_in_range;
    logic [AW-1:0] w_idx;
    logic        w_mem_wr;

    assign w_hs = (r_state == S_IDLE) && req_i;

    // With LATENCY=0 the commit edge is the grant edge, so the access uses the live inputs.
    assign w_acc_we    = (r_state == S_IDLE) ? we_i    : r_we;
    assign w_acc_be    = (r_state == S_IDLE) ? be_i    : r_be;
    assign w_acc_addr  = (r_state == S_IDLE) ? addr_i  : r_addr;
    assign w_acc_wdata = (r_state == S_IDLE) ? wdata_i : r_wdata;

    assign w_word_addr = w_acc_addr >> 3;
    assign w_in_range  = (w_word_addr < 64'(DEPTH_WORDS));
    assign w_idx       = w_word_addr[AW-1:0];
    assign w_commit    = (w_state_nxt == S_RESP);
    assign w_mem_wr    = rst_n && w_commit && w_acc_we && w_in_range;

    // NOTE: every output of this block gets a default first so no latch is inferred.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (req_i) begin
                    w_cnt_nxt   = 4'(LATENCY);
                    w_state_nxt = (LATENCY == 0) ? S_RESP : S_WAIT;
                end
            end
            S_WAIT: begin
                w_cnt_nxt = r_cnt - 4'd1;
                if (r_cnt == 4'd1) begin
                    w_state_nxt = S_RESP;
                end
            end
            S_RESP:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops see pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_we    <= 1'b0;
            r_be    <= '0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_hs) begin
                r_we    <= we_i;
                r_be    <= be_i;
                r_addr  <= addr_i;
                r_wdata <= wdata_i;
            end
            r_err <= w_commit && !w_in_range;
            if (w_commit && !w_acc_we && w_in_range) begin
                r_rdata <= r_mem[w_idx];
            end else begin
                r_rdata <= '0;
            end
        end
    end

    // NOTE: the array has no reset; contents survive rst_n, and writes are gated so a
    // transaction cut off by reset never commits.
    always_ff @(posedge clk) begin
        if (w_mem_wr) begin
            for (int k = 0; k < 8; k++) begin
                if (w_acc_be[k]) begin
                    r_mem[w_idx][8*k +: 8] <= w_acc_wdata[8*k +: 8];
                end
            end
        end
    end

    assign gnt_o    = rst_n && (r_state == S_IDLE);
    assign rvalid_o = (r_state == S_RESP);
    assign rdata_o  = r_rdata;
    assign err_o    = r_err;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: a transaction-level model (sparse memory plus one pending
// response with a due cycle) checked every cycle, plus directed vectors with literal results.
module tb_dmem_responder;

    localparam int DEPTH = 4096;
    localparam int LAT   = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_i = 1'b0;
    logic        req0_i = 1'b0;
    logic        we_i = 1'b0;
    logic [7:0]  be_i = '0;
    logic [63:0] addr_i = '0;
    logic [63:0] wdata_i = '0;
    logic        gnt_o, rvalid_o, err_o;
    logic [63:0] rdata_o;
    logic        gnt0_o, rvalid0_o, err0_o;
    logic [63:0] rdata0_o;

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
        .clk(clk), .rst_n(rst_n), .req_i(req_i), .we_i(we_i), .be_i(be_i),
        .addr_i(addr_i), .wdata_i(wdata_i), .gnt_o(gnt_o), .rvalid_o(rvalid_o),
        .rdata_o(rdata_o), .err_o(err_o)
    );

    dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .req_i(req0_i), .we_i(we_i), .be_i(be_i),
        .addr_i(addr_i), .wdata_i(wdata_i), .gnt_o(gnt0_o), .rvalid_o(rvalid0_o),
        .rdata_o(rdata0_o), .err_o(err0_o)
    );

    int     n_checks = 0;
    int     n_fail   = 0;
    longint ecnt     = 0;

    always @(posedge clk) ecnt <= ecnt + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%h expected 0x%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model state: sparse memory and the single pending transaction.
    logic [63:0] mdl_mem [longint];
    bit          pend = 1'b0;
    longint      pend_due;
    logic        pend_we;
    logic [7:0]  pend_be;
    logic [63:0] pend_addr;
    logic [63:0] pend_wdata;

    always @(negedge clk) begin : compare
        bit     was_idle;
        bit     exp_v;
        bit     inr;
        longint word;
        if (!rst_n) begin
            pend = 1'b0;
            check("gnt_in_reset", gnt_o, 0);
            check("rvalid_in_reset", rvalid_o, 0);
            check("rdata_in_reset", rdata_o, 0);
        end else begin
            was_idle = !pend;
            exp_v    = pend && (pend_due == ecnt);
            check("gnt", gnt_o, was_idle);
            check("rvalid", rvalid_o, exp_v);
            if (exp_v) begin
                inr  = (pend_addr < 64'(DEPTH) * 64'd8);
                word = longint'(pend_addr >> 3);
                check("err", err_o, !inr);
                if (!inr || pend_we) begin
                    check("rdata_zero", rdata_o, 0);
                end else if (mdl_mem.exists(word)) begin
                    check("rdata", rdata_o, mdl_mem[word]);
                end
                if (inr && pend_we) begin
                    if (mdl_mem.exists(word)) begin
                        for (int k = 0; k < 8; k++)
                            if (pend_be[k]) mdl_mem[word][8*k +: 8] = pend_wdata[8*k +: 8];
                    end else if (pend_be == 8'hFF) begin
                        mdl_mem[word] = pend_wdata;
                    end
                end
                pend = 1'b0;
            end else begin
                check("rdata_idle", rdata_o, 0);
            end
            if (was_idle && req_i) begin
                pend       = 1'b1;
                pend_due   = ecnt + LAT + 1;
                pend_we    = we_i;
                pend_be    = be_i;
                pend_addr  = addr_i;
                pend_wdata = wdata_i;
            end
        end
    end

    // One complete transaction on dut (sel=0) or the zero-latency dut0 (sel=1).
    // lat = response cycle minus handshake edge index.
    task automatic do_txn(input bit sel, input logic we, input logic [7:0] be,
                          input logic [63:0] addr, input logic [63:0] wdata,
                          output logic [63:0] rd, output logic er, output int lat);
        longint h;
        int     t;
        rd  = '0;
        er  = 1'b0;
        lat = -1;
        @(posedge clk);
        #1;
        we_i = we; be_i = be; addr_i = addr; wdata_i = wdata;
        if (sel) req0_i = 1'b1; else req_i = 1'b1;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!(sel ? gnt0_o : gnt_o) && t < 20);
        if (!(sel ? gnt0_o : gnt_o)) begin
            check("grant_timeout", sel ? gnt0_o : gnt_o, 1);
            req_i = 1'b0; req0_i = 1'b0;
            return;
        end
        h = ecnt;
        @(posedge clk);
        #1;
        req_i = 1'b0; req0_i = 1'b0;
        we_i = ~we; be_i = ~be; addr_i = ~addr; wdata_i = ~wdata;
        if (!(sel ? rvalid0_o : rvalid_o)) begin
            t = 0;
            do begin
                @(negedge clk);
                t++;
            end while (!(sel ? rvalid0_o : rvalid_o) && t < 20);
        end else begin
            @(negedge clk);
        end
        if (!(sel ? rvalid0_o : rvalid_o)) begin
            check("rvalid_timeout", sel ? rvalid0_o : rvalid_o, 1);
            return;
        end
        rd  = sel ? rdata0_o : rdata_o;
        er  = sel ? err0_o : err_o;
        lat = int'(ecnt - h);
    endtask

    logic [63:0] rd;
    logic        er;
    int          lat;

    initial begin
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("post_reset_gnt", gnt_o, 1);
        check("post_reset_rdata", rdata_o, 0);

        // Full store then load back, latency 2 -> response three cycles after grant edge.
        do_txn(0, 1'b1, 8'hFF, 64'h10, 64'hDEADBEEF_CAFEF00D, rd, er, lat);
        check("t1_store_lat", 64'(lat), 3);
        check("t1_store_err", er, 0);
        do_txn(0, 1'b0, 8'h00, 64'h10, 64'h0, rd, er, lat);
        check("t1_load_data", rd, 64'hDEADBEEF_CAFEF00D);
        check("t1_load_lat", 64'(lat), 3);

        // Partial store merges lanes; be=0 store leaves the word alone.
        do_txn(0, 1'b1, 8'hFF, 64'h18, 64'hAAAAAAAA_BBBBBBBB, rd, er, lat);
        do_txn(0, 1'b1, 8'h0F, 64'h18, 64'h11111111_22222222, rd, er, lat);
        check("t2_store_rdata", rd, 0);
        do_txn(0, 1'b0, 8'h00, 64'h18, 64'h0, rd, er, lat);
        check("t2_partial", rd, 64'hAAAAAAAA_22222222);
        do_txn(0, 1'b1, 8'h00, 64'h18, 64'h33333333_44444444, rd, er, lat);
        do_txn(0, 1'b0, 8'h00, 64'h18, 64'h0, rd, er, lat);
        check("t2_be_zero", rd, 64'hAAAAAAAA_22222222);

        // Request held high across three loads: grants spaced LAT+2 apart, three responses.
        begin
            longint gt[3];
            logic [63:0] addrs[3];
            int grants, rv;
            addrs[0] = 64'h10; addrs[1] = 64'h18; addrs[2] = 64'h10;
            grants = 0; rv = 0;
            @(posedge clk);
            #1 req_i = 1'b1; we_i = 1'b0; be_i = 8'h00; addr_i = addrs[0];
            for (int c = 0; c < 40 && grants < 3; c++) begin
                @(negedge clk);
                if (rvalid_o) rv++;
                if (gnt_o && req_i) begin
                    gt[grants] = ecnt;
                    grants++;
                    @(posedge clk);
                    #1;
                    if (grants < 3) addr_i = addrs[grants];
                    else req_i = 1'b0;
                end
            end
            req_i = 1'b0;
            for (int c = 0; c < 8; c++) begin
                @(negedge clk);
                if (rvalid_o) rv++;
            end
            check("t3_grants", 64'(grants), 3);
            check("t3_rvalids", 64'(rv), 3);
            if (grants == 3) begin
                check("t3_spacing_a", 64'(gt[1] - gt[0]), 4);
                check("t3_spacing_b", 64'(gt[2] - gt[1]), 4);
            end
        end

        // Out-of-range: error flagged, zero data, aliased word 0 untouched.
        do_txn(0, 1'b1, 8'hFF, 64'h0, 64'h01234567_89ABCDEF, rd, er, lat);
        do_txn(0, 1'b0, 8'h00, 64'(DEPTH) * 8, 64'h0, rd, er, lat);
        check("t4_load_err", er, 1);
        check("t4_load_data", rd, 0);
        do_txn(0, 1'b1, 8'hFF, 64'(DEPTH) * 8, 64'hFFFFFFFF_FFFFFFFF, rd, er, lat);
        check("t4_store_err", er, 1);
        do_txn(0, 1'b0, 8'h00, 64'h0, 64'h0, rd, er, lat);
        check("t4_word0", rd, 64'h01234567_89ABCDEF);
        check("t4_word0_err", er, 0);

        // Zero-latency instance: response in the cycle right after the grant edge.
        do_txn(1, 1'b1, 8'hFF, 64'h8, 64'h0000_0000_0000_FEED, rd, er, lat);
        check("t5_store_lat", 64'(lat), 1);
        do_txn(1, 1'b0, 8'h00, 64'h8, 64'h0, rd, er, lat);
        check("t5_load_lat", 64'(lat), 1);
        check("t5_load_data", rd, 64'h0000_0000_0000_FEED);

        // Reset during WAIT of a store: no response, old contents persist.
        do_txn(0, 1'b1, 8'hFF, 64'h20, 64'h5, rd, er, lat);
        begin
            int rv;
            int t;
            rv = 0;
            @(posedge clk);
            #1 req_i = 1'b1; we_i = 1'b1; be_i = 8'hFF; addr_i = 64'h20; wdata_i = 64'h99;
            t = 0;
            do begin
                @(negedge clk);
                t++;
            end while (!gnt_o && t < 20);
            check("t6_grant", gnt_o, 1);
            @(posedge clk);
            #1 req_i = 1'b0;
            rst_n = 1'b0;
            for (int c = 0; c < 3; c++) begin
                @(negedge clk);
                if (rvalid_o) rv++;
            end
            check("t6_gnt_in_reset", gnt_o, 0);
            @(posedge clk);
            #1 rst_n = 1'b1;
            for (int c = 0; c < 3; c++) begin
                @(negedge clk);
                if (rvalid_o) rv++;
            end
            check("t6_no_rvalid", 64'(rv), 0);
        end
        do_txn(0, 1'b0, 8'h00, 64'h20, 64'h0, rd, er, lat);
        check("t6_load_data", rd, 64'h5);

        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
